// File: rtl/seq_pkg.sv
// Shared definitions for the phase sequencer: slot indices, SEQTYPE
// encodings and the step-counter layout.
package seq_pkg;

    localparam int SLOT_W = 4;

    // Slot indices in sequencing order; execute slots follow SLOT_EX1.
    localparam logic [SLOT_W-1:0] SLOT_FETCH    = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_AUTOINC1 = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_AUTOINC2 = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_INDIRECT = 4'd3;
    localparam logic [SLOT_W-1:0] SLOT_EX1      = 4'd4;

    // SEQTYPE encodings: bit1 = auto-increment indirect, bit0 = indirect.
    localparam logic [1:0] SEQTYPE_DIRECT   = 2'b00;
    localparam logic [1:0] SEQTYPE_INDIRECT = 2'b01;
    localparam logic [1:0] SEQTYPE_AUTOINC  = 2'b10;

    // Each slot lasts two cycles: a CK-only half, then a strobe half.
    typedef enum logic {
        SUB_CK  = 1'b0,
        SUB_STB = 1'b1
    } sub_e;

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        sub_e              sub;
    } step_t;

    // First slot after fetch, chosen by the addressing mode.
    function automatic logic [SLOT_W-1:0] slot_after_fetch(input logic [1:0] seqtype);
        logic [SLOT_W-1:0] next_slot;
        if (seqtype[1]) begin
            next_slot = SLOT_AUTOINC1;
        end else if (seqtype[0]) begin
            next_slot = SLOT_INDIRECT;
        end else begin
            next_slot = SLOT_EX1;
        end
        return next_slot;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// Registered rising-edge detector: EDGE is high in the first cycle that D
// is seen high after having been low.
module rise_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic EDGE
);

    logic prev_q;

    // Remember last cycle's level of D.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (RESET) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= D;
        end
    end

    assign EDGE = D & ~prev_q;

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks FETCH, optional AUTOINC/INDIRECT
// slots and EX1..EXn, two cycles per slot, with run/halt control.
// Optional feature: define PHASE_SEQUENCER_STEP_EN to add the STEP input
// for single-instruction stepping.
module phase_sequencer
    import seq_pkg::*;
#(
    parameter  int NPHASE = 6,
    localparam int NSLOT  = 4 + NPHASE
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             HALT,
    input  logic             DONE,
    input  logic [1:0]       SEQTYPE,
`ifdef PHASE_SEQUENCER_STEP_EN
    input  logic             STEP,
`endif
    output logic [NSLOT-1:0] CK,
    output logic [NSLOT-1:0] STB,
    output logic [3:0]       SLOT,
    output logic             RUNNING,
    output logic             INSTR_END
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NSLOT - 1);

    step_t step_q, step_d;
    logic  running_q, running_d;
    logic  halt_pending_q, halt_pending_d;
    logic  instr_end_q, instr_end_d;

    logic  run_edge, halt_edge;
    logic  start;        // begin running this cycle (when idle)
    logic  single_shot;  // the run being started stops after one instruction
    logic  halt_accept;  // a HALT edge that applies to the current/new run
    logic  at_rest;

    rise_edge u_run_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (RUN),
        .EDGE  (run_edge)
    );

    rise_edge u_halt_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (HALT),
        .EDGE  (halt_edge)
    );

    // HALT only counts while running or when a run starts in the same cycle.
    assign halt_accept = halt_edge & (running_q | run_edge);
    assign at_rest     = (step_q.slot == SLOT_FETCH) && (step_q.sub == SUB_CK);

`ifdef PHASE_SEQUENCER_STEP_EN
    logic step_edge;

    rise_edge u_step_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (STEP),
        .EDGE  (step_edge)
    );

    // A step is a run that is pre-armed to halt after one instruction.
    assign start       = run_edge | step_edge;
    assign single_shot = halt_accept | step_edge;
`else
    assign start       = run_edge;
    assign single_shot = halt_accept;
`endif

    // Next step, instruction-end pulse and run/halt flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        step_d         = step_q;
        running_d      = running_q;
        halt_pending_d = halt_pending_q;
        instr_end_d    = 1'b0;

        if (DONE) begin
            step_d      = '{SLOT_FETCH, SUB_CK};
            instr_end_d = !(at_rest && !running_q);
        end else if (running_q) begin
            if (step_q.sub == SUB_CK) begin
                step_d.sub = SUB_STB;
            end else if (step_q.slot == SLOT_FETCH) begin
                step_d = '{slot_after_fetch(SEQTYPE), SUB_CK};
            end else if (step_q.slot == SLOT_LAST) begin
                step_d      = '{SLOT_FETCH, SUB_CK};
                instr_end_d = 1'b1;
            end else begin
                step_d = '{step_q.slot + SLOT_W'(1), SUB_CK};
            end
        end

        if (!running_q) begin
            if (start) begin
                running_d      = 1'b1;
                halt_pending_d = single_shot;
            end
        end else if (instr_end_d) begin
            running_d      = !(halt_pending_q || halt_accept);
            halt_pending_d = 1'b0;
        end else if (halt_accept) begin
            halt_pending_d = 1'b1;
        end
    end

    // State registers; reset abandons any instruction without an end pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            step_q         <= '{SLOT_FETCH, SUB_CK};
            running_q      <= 1'b0;
            halt_pending_q <= 1'b0;
            instr_end_q    <= 1'b0;
        end else begin
            step_q         <= step_d;
            running_q      <= running_d;
            halt_pending_q <= halt_pending_d;
            instr_end_q    <= instr_end_d;
        end
    end

    // One-hot slot and strobe vectors decoded from the step counter.
    always_comb begin
        CK  = '0;
        STB = '0;
        for (int s = 0; s < NSLOT; s++) begin
            CK[s]  = (step_q.slot == SLOT_W'(s));
            STB[s] = (step_q.slot == SLOT_W'(s)) && (step_q.sub == SUB_STB);
        end
    end

    assign SLOT      = step_q.slot;
    assign RUNNING   = running_q;
    assign INSTR_END = instr_end_q;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NPHASE, default 6: number of execute phases EX1..EXn; legal range 1..8.
REQ-002 Parameter NSLOT, derived, = 4+NPHASE: slot count; slot order FETCH(0), AUTOINC1(1), AUTOINC2(2), INDIRECT(3), EX1..EXn(4..NSLOT-1).
REQ-003 CLK  input  1  clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 RUN  input  1  rising edge starts continuous run.
REQ-006 HALT  input  1  rising edge requests a stop at the next instruction end.
REQ-007 DONE  input  1  early end of the current instruction.
REQ-008 SEQTYPE  input  2  bit1 = auto-increment indirect, bit0 = indirect.
REQ-009 CK  output  NSLOT  one-hot slot-active vector.
REQ-010 STB  output  NSLOT  one-hot strobe vector; second cycle of a slot only.
REQ-011 SLOT  output  4  current slot index.
REQ-012 RUNNING  output  1  run flag.
REQ-013 INSTR_END  output  1  one-cycle registered pulse when the sequencer returns to slot 0.

Function
REQ-014 State: step counter = {slot, sub}, where sub 0 = CK phase and sub 1 = STB phase; CK[s] = (slot==s), STB[s] = (slot==s && sub==1), both purely decoded from the counter.
REQ-015 Edge detect: RUN and HALT are each registered once; edge = current & ~previous; previous registers reset to 0.
REQ-016 RUN edge while RUNNING=0 sets RUNNING on the next cycle; counter starts advancing the cycle after that.
REQ-017 While RUNNING=0 the counter holds; CK[0] stays high at rest.
REQ-018 Advance, 1 step per cycle, except leaving step {FETCH,1}: SEQTYPE 00 -> {EX1,0}; 01 -> {INDIRECT,0}; 1x -> {AUTOINC1,0}.
REQ-019 Step {EXn,1} (last execute slot) -> {FETCH,0} with INSTR_END=1; never wraps beyond NSLOT.
REQ-020 DONE=1 forces {FETCH,0} and INSTR_END=1 regardless of RUNNING; DONE while already at {FETCH,0} and not running leaves INSTR_END=0.
REQ-021 HALT edge sets halt_pending; at the next instruction end, RUNNING clears, halt_pending clears, and the counter rests at {FETCH,0}.
REQ-022 RUN and HALT edges in the same cycle: RUNNING sets and halt_pending sets; exactly one instruction executes.
REQ-023 HALT edge while not running is ignored.
REQ-024 Priority: RESET > DONE > advance.

Reset
REQ-025 RESET: counter {FETCH,0}, RUNNING=0, halt_pending=0, INSTR_END=0, edge registers 0; outputs are valid the cycle after reset with CK=1, STB=0, SLOT=0.
REQ-026 RESET mid-instruction abandons it at once; INSTR_END is not pulsed.

Configuration
REQ-027 Macro PHASE_SEQUENCER_STEP_EN defined: adds input STEP (1 bit); a STEP rising edge while RUNNING=0 runs exactly one instruction and then rests at {FETCH,0} with RUNNING=0; STEP is ignored while running.
REQ-028 Macro undefined: no STEP port and no single-step logic; behaviour otherwise identical.

Structure
REQ-029 Shared package seq_pkg holds the slot index constants (SLOT_FETCH, SLOT_AUTOINC1, SLOT_AUTOINC2, SLOT_INDIRECT, SLOT_EX1) and the SEQTYPE encoding constants.
REQ-030 Sub-module rise_edge (1-bit registered rising-edge detector) is instantiated for RUN, HALT and, when enabled, STEP.

Verification
REQ-031 Reset, then RUN pulse, SEQTYPE=00, NPHASE=6: the 2nd fetch cycle goes to slot 4; STB[4..9] each pulse once; INSTR_END pulses 1 after slot 9 sub 1; repeats.
REQ-032 SEQTYPE=01 -> slots 0,3,4..9; SEQTYPE=10 -> slots 0,1,2,3,4..9, with per-slot STB counts checked.
REQ-033 DONE asserted at slot 5 sub 0: next cycle is slot 0, INSTR_END=1, and slots 6..9 never strobe.
REQ-034 HALT pulse at slot 6: the instruction completes, RUNNING=0 at slot 0, and the counter holds for 20 cycles; a RUN pulse then resumes.
REQ-035 RESET asserted at slot 7 sub 1: next cycle slot 0, RUNNING=0, INSTR_END=0; RUN and HALT pulsed in the same cycle then yield exactly one instruction.
REQ-036 With PHASE_SEQUENCER_STEP_EN defined: STEP pulse runs one instruction (10 strobes total with SEQTYPE=10) and then stops; a STEP pulse during RUN is ignored.
